// File: rtl/fpu_ss_pkg.sv
// Shared definitions for the FPU subsystem offload path: commit buffer defaults
// and the per-entry status record.
package fpu_ss_pkg;

  localparam int COMMIT_BUF_DEPTH = 4;
  localparam int INSTR_WIDTH      = 32;
  localparam int MODE_WIDTH       = 2;

  typedef struct packed {
    logic valid;
    logic committed;
    logic killed;
  } commit_buf_status_t;

endpackage

// File: rtl/fpu_ss_id_match.sv
// Combinational id lookup for the commit buffer: one-hot match over stored entries
// plus a flag for the entry being pushed in the same cycle.
module fpu_ss_id_match #(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic [DEPTH-1:0][ID_WIDTH-1:0] ids_i,
  input  logic [DEPTH-1:0]               valid_i,
  input  logic [ID_WIDTH-1:0]            push_id_i,
  input  logic                           push_en_i,
  input  logic [ID_WIDTH-1:0]            commit_id_i,
  input  logic                           commit_valid_i,
  output logic [DEPTH-1:0]               match_o,
  output logic                           push_hit_o
);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = commit_valid_i && valid_i[i] && (ids_i[i] == commit_id_i);
    end
  end

  assign push_hit_o = commit_valid_i && push_en_i && (push_id_i == commit_id_i);

endmodule

// File: rtl/fpu_ss_commit_buffer.sv
// Commit-aware offload buffer: keeps offloaded instructions in program order and
// releases the head only once the core has committed its id; killed entries are dropped.
module fpu_ss_commit_buffer
  import fpu_ss_pkg::*;
#(
  parameter int DEPTH      = COMMIT_BUF_DEPTH,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_RS     = 3,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [INSTR_WIDTH-1:0]       push_instr_i,
  input  logic [NUM_RS*DATA_WIDTH-1:0] push_rs_i,
  input  logic [ID_WIDTH-1:0]          push_id_i,
  input  logic [MODE_WIDTH-1:0]        push_mode_i,
  input  logic                         commit_valid_i,
  input  logic [ID_WIDTH-1:0]          commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         pop_valid_o,
  input  logic                         pop_ready_i,
  output logic [INSTR_WIDTH-1:0]       pop_instr_o,
  output logic [NUM_RS*DATA_WIDTH-1:0] pop_rs_o,
  output logic [ID_WIDTH-1:0]          pop_id_o,
  output logic [MODE_WIDTH-1:0]        pop_mode_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]                              r_wr_ptr;
  logic [PW-1:0]                              r_rd_ptr;
  commit_buf_status_t [DEPTH-1:0]             r_status;
  logic [DEPTH-1:0][INSTR_WIDTH-1:0]          r_instr;
  logic [DEPTH-1:0][NUM_RS*DATA_WIDTH-1:0]    r_rs;
  logic [DEPTH-1:0][ID_WIDTH-1:0]             r_id;
  logic [DEPTH-1:0][MODE_WIDTH-1:0]           r_mode;

  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_push_fire;
  logic             w_head_valid;
  logic             w_discard;
  logic             w_head_fire;
  logic [DEPTH-1:0] w_valid_vec;
  logic [DEPTH-1:0] w_match;
  logic             w_push_hit;
  logic             w_push_dup;
  commit_buf_status_t w_head_st;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign push_ready_o = !w_full;
  assign w_push_fire  = push_valid_i && push_ready_o;

  always_comb begin
    w_valid_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i] = r_status[i].valid;
    end
  end

  fpu_ss_id_match #(
    .DEPTH    (DEPTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_id_match (
    .ids_i          (r_id),
    .valid_i        (w_valid_vec),
    .push_id_i      (push_id_i),
    .push_en_i      (w_push_fire),
    .commit_id_i    (commit_id_i),
    .commit_valid_i (commit_valid_i),
    .match_o        (w_match),
    .push_hit_o     (w_push_hit)
  );

  assign w_head_st    = r_status[w_rd_idx];
  assign w_head_valid = !w_empty && w_head_st.valid;
  assign pop_valid_o  = w_head_valid && w_head_st.committed && !w_head_st.killed;
  assign w_discard    = w_head_valid && w_head_st.killed;
  assign w_head_fire  = (pop_valid_o && pop_ready_i) || w_discard;

  assign pop_instr_o = r_instr[w_rd_idx];
  assign pop_rs_o    = r_rs[w_rd_idx];
  assign pop_id_o    = r_id[w_rd_idx];
  assign pop_mode_o  = r_mode[w_rd_idx];

  assign count_o = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_head_fire) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // A commit after a kill must not revive the entry; a push overrides any stale status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_status <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_match[i]) begin
          if (commit_kill_i)            r_status[i].killed    <= 1'b1;
          else if (!r_status[i].killed) r_status[i].committed <= 1'b1;
        end
        if (w_head_fire && (AW'(i) == w_rd_idx)) begin
          r_status[i].valid <= 1'b0;
        end
        if (w_push_fire && (AW'(i) == w_wr_idx)) begin
          r_status[i] <= '{valid:     1'b1,
                           committed: w_push_hit && !commit_kill_i,
                           killed:    w_push_hit && commit_kill_i};
        end
      end
    end
  end

  // NOTE: payload RAM has no reset; the status bits alone decide what is live.
  always_ff @(posedge clk_i) begin
    if (w_push_fire) begin
      r_instr[w_wr_idx] <= push_instr_i;
      r_rs[w_wr_idx]    <= push_rs_i;
      r_id[w_wr_idx]    <= push_id_i;
      r_mode[w_wr_idx]  <= push_mode_i;
    end
  end

  always_comb begin
    w_push_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid_vec[i] && (r_id[i] == push_id_i)) w_push_dup = 1'b1;
    end
  end

  a_unique_push_id: assert property (@(posedge clk_i) disable iff (rst_i)
    w_push_fire |-> !w_push_dup);

endmodule

// File: tb/tb_fpu_ss_commit_buffer.sv
// Bench for the commit buffer: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the buffer's behaviour.
module tb_fpu_ss_commit_buffer;

  localparam int DEPTH      = 4;
  localparam int ID_WIDTH   = 4;
  localparam int NUM_RS     = 3;
  localparam int DATA_WIDTH = 32;
  localparam int RSW        = NUM_RS * DATA_WIDTH;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic                   push_valid_i;
  logic                   push_ready_o;
  logic [31:0]            push_instr_i;
  logic [RSW-1:0]         push_rs_i;
  logic [ID_WIDTH-1:0]    push_id_i;
  logic [1:0]             push_mode_i;
  logic                   commit_valid_i;
  logic [ID_WIDTH-1:0]    commit_id_i;
  logic                   commit_kill_i;
  logic                   pop_valid_o;
  logic                   pop_ready_i;
  logic [31:0]            pop_instr_o;
  logic [RSW-1:0]         pop_rs_o;
  logic [ID_WIDTH-1:0]    pop_id_o;
  logic [1:0]             pop_mode_o;
  logic [$clog2(DEPTH):0] count_o;

  fpu_ss_commit_buffer #(
    .DEPTH      (DEPTH),
    .ID_WIDTH   (ID_WIDTH),
    .NUM_RS     (NUM_RS),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_valid_i   (push_valid_i),
    .push_ready_o   (push_ready_o),
    .push_instr_i   (push_instr_i),
    .push_rs_i      (push_rs_i),
    .push_id_i      (push_id_i),
    .push_mode_i    (push_mode_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .pop_valid_o    (pop_valid_o),
    .pop_ready_i    (pop_ready_i),
    .pop_instr_o    (pop_instr_o),
    .pop_rs_o       (pop_rs_o),
    .pop_id_o       (pop_id_o),
    .pop_mode_o     (pop_mode_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         instr;
    logic [RSW-1:0]      rs;
    logic [1:0]          mode;
    bit                  committed;
    bit                  killed;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive(input bit pv, input logic [ID_WIDTH-1:0] pid, input bit cv,
                       input logic [ID_WIDTH-1:0] cid, input bit kill, input bit prdy);
    push_valid_i = pv;
    push_id_i    = pid;
    push_instr_i = $urandom();
    for (int k = 0; k < NUM_RS; k++) push_rs_i[k*DATA_WIDTH +: DATA_WIDTH] = $urandom();
    push_mode_i    = 2'($urandom_range(0, 3));
    commit_valid_i = cv;
    commit_id_i    = cid;
    commit_kill_i  = kill;
    pop_ready_i    = prdy;
  endtask

  task automatic idle(input bit prdy);
    drive(1'b0, '0, 1'b0, '0, 1'b0, prdy);
  endtask

  // Reference: a program-ordered list of live entries; the head leaves when it is
  // killed or committed-and-taken, and pushes are accepted only if not already full.
  task automatic model_apply();
    ent_t e;
    bit   push_ok;
    push_ok = push_valid_i && (q.size() < DEPTH);
    if (q.size() > 0) begin
      if (q[0].killed || (q[0].committed && pop_ready_i)) void'(q.pop_front());
    end
    if (commit_valid_i) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].id == commit_id_i) begin
          if (commit_kill_i) q[i].killed = 1'b1;
          else if (!q[i].killed) q[i].committed = 1'b1;
        end
      end
    end
    if (push_ok) begin
      e.id        = push_id_i;
      e.instr     = push_instr_i;
      e.rs        = push_rs_i;
      e.mode      = push_mode_i;
      e.committed = commit_valid_i && (commit_id_i == push_id_i) && !commit_kill_i;
      e.killed    = commit_valid_i && (commit_id_i == push_id_i) && commit_kill_i;
      q.push_back(e);
    end
  endtask

  task automatic compare();
    bit exp_pv;
    exp_pv = 1'b0;
    if (q.size() > 0) exp_pv = q[0].committed && !q[0].killed;
    check("push_ready", 128'(push_ready_o), 128'(q.size() < DEPTH));
    check("pop_valid", 128'(pop_valid_o), 128'(exp_pv));
    check("count", 128'(count_o), 128'(q.size()));
    if (exp_pv) begin
      check("pop_id", 128'(pop_id_o), 128'(q[0].id));
      check("pop_instr", 128'(pop_instr_o), 128'(q[0].instr));
      check("pop_rs", 128'(pop_rs_o), 128'(q[0].rs));
      check("pop_mode", 128'(pop_mode_o), 128'(q[0].mode));
    end
  endtask

  task automatic step();
    model_apply();
    @(posedge clk_i);
    #1;
    compare();
  endtask

  task automatic do_reset();
    idle(1'b0);
    rst_i = 1'b1;
    q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    compare();
  endtask

  function automatic bit in_q(input logic [ID_WIDTH-1:0] id);
    foreach (q[i]) if (q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [ID_WIDTH-1:0] nid;
    logic [ID_WIDTH-1:0] hid;
    logic [ID_WIDTH-1:0] pid;
    logic [ID_WIDTH-1:0] cid;
    bit                  pv;
    bit                  cv;

    idle(1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    compare();
    rst_i = 1'b0;

    // Reset in the middle of traffic takes effect without waiting for a clock edge.
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, ID_WIDTH'(k), 1'b0, '0, 1'b0, 1'b0);
      step();
    end
    check("t1_count_before", 128'(count_o), 128'(3));
    idle(1'b0);
    rst_i = 1'b1;
    #1;
    q.delete();
    check("t1_rst_count", 128'(count_o), 128'(0));
    check("t1_rst_pop_valid", 128'(pop_valid_o), 128'(0));
    check("t1_rst_push_ready", 128'(push_ready_o), 128'(1));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    compare();

    // In-order commit and pop.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, ID_WIDTH'(k), 1'b0, '0, 1'b0, 1'b1);
      step();
    end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, '0, 1'b1, ID_WIDTH'(k), 1'b0, 1'b1);
      step();
      check("t2_pop_id", 128'(pop_id_o), 128'(k));
    end
    idle(1'b1);
    repeat (2) step();
    check("t2_drained", 128'(count_o), 128'(0));

    // Out-of-order commit.
    do_reset();
    drive(1'b1, 4'd5, 1'b0, '0, 1'b0, 1'b1); step();
    drive(1'b1, 4'd6, 1'b0, '0, 1'b0, 1'b1); step();
    drive(1'b0, '0, 1'b1, 4'd6, 1'b0, 1'b1); step();
    check("t3_hold", 128'(pop_valid_o), 128'(0));
    drive(1'b0, '0, 1'b1, 4'd5, 1'b0, 1'b1); step();
    check("t3_first", 128'(pop_id_o), 128'(5));
    idle(1'b1); step();
    check("t3_second", 128'(pop_id_o), 128'(6));
    step();

    // Kill at head.
    do_reset();
    drive(1'b1, 4'd7, 1'b0, '0, 1'b0, 1'b1); step();
    drive(1'b1, 4'd8, 1'b0, '0, 1'b0, 1'b1); step();
    drive(1'b0, '0, 1'b1, 4'd7, 1'b1, 1'b1); step();
    check("t4_killed_hidden", 128'(pop_valid_o), 128'(0));
    drive(1'b0, '0, 1'b1, 4'd8, 1'b0, 1'b1); step();
    check("t4_pop8", 128'(pop_id_o), 128'(8));
    idle(1'b1); step();
    check("t4_count0", 128'(count_o), 128'(0));

    // Full and wrap: three laps through a DEPTH-4 buffer.
    do_reset();
    nid = '0;
    hid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, nid, 1'b0, '0, 1'b0, 1'b1);
      step();
      nid = nid + 1'b1;
    end
    check("t5_full", 128'(push_ready_o), 128'(0));
    for (int lap = 0; lap < 3 * DEPTH; lap++) begin
      drive(1'b1, nid, 1'b1, hid, 1'b0, 1'b0);
      step();
      check("t5_head_id", 128'(pop_id_o), 128'(hid));
      idle(1'b1);
      step();
      check("t5_ready_again", 128'(push_ready_o), 128'(1));
      drive(1'b1, nid, 1'b0, '0, 1'b0, 1'b0);
      step();
      nid = nid + 1'b1;
      hid = hid + 1'b1;
    end

    // Same-cycle push+commit, then a commit for an id nobody holds.
    do_reset();
    drive(1'b1, 4'd9, 1'b1, 4'd9, 1'b0, 1'b0); step();
    check("t6_valid", 128'(pop_valid_o), 128'(1));
    check("t6_id", 128'(pop_id_o), 128'(9));
    drive(1'b0, '0, 1'b1, 4'hF, 1'b0, 1'b0); step();
    check("t6_unknown_count", 128'(count_o), 128'(1));
    idle(1'b1); step();

    // Random traffic.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pv = ($urandom_range(0, 99) < 60);
      do pid = ID_WIDTH'($urandom_range(0, 15)); while (in_q(pid));
      cv  = ($urandom_range(0, 99) < 50);
      cid = ID_WIDTH'($urandom_range(0, 15));
      if (q.size() > 0 && $urandom_range(0, 99) < 70) cid = q[$urandom_range(0, q.size() - 1)].id;
      if (pv && $urandom_range(0, 99) < 15) cid = pid;
      drive(pv, pid, cv, cid, ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 70));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
